// File: rtl/vga_anim_pkg.sv
// Shared definitions for the VGA animation controller.
// Holds the display/sprite geometry, the derived centre and limit constants,
// the animation-mode and run-state encodings, and the per-axis step helpers
// used by the top level.
package vga_anim_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int SPRITE_W = 32;
    localparam int SPRITE_H = 32;
    localparam int STEP     = 2;

    // Largest legal sprite left/top edge (11-bit to match the step arithmetic)
    localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - SPRITE_W);
    localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - SPRITE_H);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [9:0]  X_CENTER = 10'((H_ACTIVE - SPRITE_W) / 2);
    localparam logic [9:0]  Y_CENTER = 10'((V_ACTIVE - SPRITE_H) / 2);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_HSCAN  = 2'd1,
        MODE_VSCAN  = 2'd2
    } anim_mode_t;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } run_state_t;

    // One axis of the sprite: position plus travel direction (1 = decreasing)
    typedef struct packed {
        logic [10:0] pos;
        logic        dir_neg;
    } axis_t;

    // Bounce one axis by STEP, clamping at either end and reversing there.
    function automatic axis_t bounce_step(input logic [10:0] pos,
                                          input logic        dir_neg,
                                          input logic [10:0] lim);
        axis_t       r;
        logic [10:0] sum;
        r.pos     = pos;
        r.dir_neg = dir_neg;
        sum       = pos + STEP_W;
        if (!dir_neg) begin
            if (sum >= lim) begin
                r.pos     = lim;
                r.dir_neg = 1'b1;
            end else begin
                r.pos = sum;
            end
        end else begin
            if (pos <= STEP_W) begin
                r.pos     = 11'd0;
                r.dir_neg = 1'b0;
            end else begin
                r.pos = pos - STEP_W;
            end
        end
        return r;
    endfunction

    // Scan one axis forward by STEP, wrapping to 0 once past the limit.
    function automatic logic [10:0] scan_step(input logic [10:0] pos,
                                              input logic [10:0] lim);
        logic [10:0] sum;
        sum = pos + STEP_W;
        return (sum > lim) ? 11'd0 : sum;
    endfunction

    function automatic anim_mode_t next_mode(input anim_mode_t m);
        anim_mode_t r;
        case (m)
            MODE_BOUNCE: r = MODE_HSCAN;
            MODE_HSCAN:  r = MODE_VSCAN;
            default:     r = MODE_BOUNCE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vga_anim_ctrl_key_debounce.sv
// Key synchronizer + debouncer with press pulse.
// Ports:
//   clk50M   - system clock
//   reset_n  - asynchronous active-low reset
//   key_raw  - raw active-low key level (asynchronous to clk50M)
//   press    - one-cycle pulse when a 1->0 transition has been accepted
// A new level is accepted after DEB_CYCLES consecutive synchronized samples
// that differ from the currently accepted level; any sample equal to the
// accepted level restarts the count, so contact bounce never gets through.
module key_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk50M,
    input  logic reset_n,
    input  logic key_raw,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= key_raw;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
                // Only the pressed direction (new level 0) produces a pulse
                press_reg <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/vga_anim_ctrl.sv
// Frame-synchronous animation controller for the VGA cartoon display.
// Ports:
//   clk50M      - 50 MHz system clock
//   reset_n     - asynchronous active-low reset
//   key[1:0]    - raw active-low keys: [0] run/pause, [1] mode
//   frame_start - one-cycle pulse at start of vertical blanking
//   sprite_x    - sprite left edge
//   sprite_y    - sprite top edge
//   anim_mode   - 0 BOUNCE, 1 HSCAN, 2 VSCAN
//   paused      - 1 while the sprite is frozen
//   frame_cnt   - frames elapsed while running (wraps)
// Key presses are latched into pending flags and only acted upon at
// frame_start, so every visible change lands between frames.
module vga_anim_ctrl
    import vga_anim_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk50M,
    input  logic       reset_n,
    input  logic [1:0] key,
    input  logic       frame_start,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic [1:0] anim_mode,
    output logic       paused,
    output logic [7:0] frame_cnt
);

    logic [1:0] press;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk50M (clk50M),
                .reset_n(reset_n),
                .key_raw(key[gi]),
                .press  (press[gi])
            );
        end
    endgenerate

    run_state_t  state_reg, state_next;
    anim_mode_t  mode_reg,  mode_next;
    logic [9:0]  x_reg,     x_next;
    logic [9:0]  y_reg,     y_next;
    logic        x_neg_reg, x_neg_next;
    logic        y_neg_reg, y_neg_next;
    logic [7:0]  cnt_reg,   cnt_next;
    logic [1:0]  pend_reg,  pend_next;

    logic [1:0]  ev;
    axis_t       ax_bounce;
    axis_t       ay_bounce;
    logic [10:0] x_scan;
    logic [10:0] y_scan;

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_PAUSE;
            mode_reg  <= MODE_BOUNCE;
            x_reg     <= X_CENTER;
            y_reg     <= Y_CENTER;
            x_neg_reg <= 1'b0;
            y_neg_reg <= 1'b0;
            cnt_reg   <= 8'd0;
            pend_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            x_neg_reg <= x_neg_next;
            y_neg_reg <= y_neg_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        x_neg_next = x_neg_reg;
        y_neg_next = y_neg_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg | press;

        // A press landing on the frame_start cycle joins this frame's events
        ev        = pend_reg | press;
        ax_bounce = bounce_step({1'b0, x_reg}, x_neg_reg, X_MAX);
        ay_bounce = bounce_step({1'b0, y_reg}, y_neg_reg, Y_MAX);
        x_scan    = scan_step({1'b0, x_reg}, X_MAX);
        y_scan    = scan_step({1'b0, y_reg}, Y_MAX);

        if (frame_start) begin
            pend_next = 2'b00;

            // Step with the state and mode as they were before this frame's events
            if (state_reg == ST_RUN) begin
                cnt_next = cnt_reg + 8'd1;
                case (mode_reg)
                    MODE_BOUNCE: begin
                        x_next     = ax_bounce.pos[9:0];
                        x_neg_next = ax_bounce.dir_neg;
                        y_next     = ay_bounce.pos[9:0];
                        y_neg_next = ay_bounce.dir_neg;
                    end
                    MODE_HSCAN: x_next = x_scan[9:0];
                    MODE_VSCAN: y_next = y_scan[9:0];
                    default: ;
                endcase
            end

            // Mode change recenters, overriding the step just computed
            if (ev[1]) begin
                mode_next  = next_mode(mode_reg);
                x_next     = X_CENTER;
                y_next     = Y_CENTER;
                x_neg_next = 1'b0;
                y_neg_next = 1'b0;
            end

            if (ev[0]) begin
                state_next = (state_reg == ST_RUN) ? ST_PAUSE : ST_RUN;
            end
        end
    end

    assign sprite_x  = x_reg;
    assign sprite_y  = y_reg;
    assign anim_mode = mode_reg;
    assign paused    = (state_reg == ST_PAUSE);
    assign frame_cnt = cnt_reg;

endmodule
